mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  Memory-access pipeline stage, directly downstream of the execute stage; feeds writeback.
//  Performs LOAD/STORE against a single-port data memory using a req/ack handshake.
//  Passes ALU results through unchanged and stalls upstream while an access is outstanding.
// PARAMETERS
//  ADDR_W   32  data-memory address width
//  DATA_W   32  register/data width (byte lanes = DATA_W/8 = 4)
//  EX_W      4  exception code width
// PORTS
//  clk                  in   1        clock
//  reset                in   1        asynchronous reset, active high
//  pipeline_in_valid    in   1        execute output valid
//  opcode_in            in   5        instr[6:2]; LOAD=5'b00000, STORE=5'b01000
//  funct_in             in   3        B=000 H=001 W=010 BU=100 HU=101
//  nop_instr_in         in   1        bubble; pass through, no writeback
//  exception_in         in   EX_W     upstream exception code
//  exception_in_valid   in   1        upstream exception present
//  result               in   DATA_W   ALU result / load address / store data
//  store_addr           in   ADDR_W   store address
//  rd_addr_in           in   5        destination register
//  flush_in             in   1        discard incoming instruction this cycle
//  stall_out            out  1        execute must hold its outputs
//  dmem_req             out  1        memory request, held until ack
//  dmem_we              out  1        1 = write
//  dmem_addr            out  ADDR_W   word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dmem_wdata           out  DATA_W   store data replicated to lanes
//  dmem_be              out  4        byte enables
//  dmem_ack             in   1        request completed this cycle
//  dmem_rdata           in   DATA_W   read data, valid with ack
//  pipeline_out_valid   out  1        writeback payload valid
//  rd_addr_out          out  5        destination register
//  wb_data              out  DATA_W   writeback value
//  wb_en                out  1        write register file (0 for stores/nop/exc/rd==0)
//  exception_out        out  EX_W     exception code
//  exception_out_valid  out  1        exception present
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE; asserting reset mid-access drops dmem_req immediately.
//  - FSM IDLE/BUSY. Capture when pipeline_in_valid & !flush_in & state==IDLE.
//  - Non-memory, nop or exception_in_valid: 1-cycle registered pass-through; no dmem_req;
//    wb_data=result, exception fields copied; wb_en=!nop & !exc & opcode!=STORE & rd!=0.
//  - LOAD addr=result; STORE addr=store_addr, data=result. Capture -> BUSY, dmem_req=1
//    registered (first req cycle = capture+1); req/we/addr/be/wdata stable until ack.
//  - BUSY & dmem_ack: req drops same edge, pipeline_out_valid=1 next cycle, ->IDLE.
//    Ack in first req cycle legal: min memory latency 2 cycles capture->output.
//  - stall_out = (state==BUSY) (registered); input ignored while BUSY.
//  - pipeline_out_valid pulses 1 cycle per retired instruction; else 0.
//  - Byte lane k=addr[1:0]: SB be=0001<<k, wdata={4{d[7:0]}}; SH be=0011<<(2*addr[1]),
//    wdata={2{d[15:0]}}; SW be=1111. Load picks lane k (B) / half addr[1] (H);
//    B/H sign-extend, BU/HU zero-extend.
//  - flush_in affects only the incoming instr; an in-flight access always completes.
//  - Back-to-back: new capture allowed in the cycle the FSM returns to IDLE.
// CONFIGURATION
//  MEM_MISALIGN_EXC_EN defined: LH/LHU/SH with addr[0]!=0 or LW/SW with addr[1:0]!=0
//    -> no dmem_req; 1-cycle output with exception_out_valid=1, exception_out=4 (load)
//    / 6 (store), wb_en=0.
//  Undefined: offending low address bits are masked to 0 and the access proceeds.
// TESTING
//  - Reset asserted mid-BUSY -> dmem_req, stall_out, pipeline_out_valid 0 asynchronously.
//  - ADD result=0x1234, rd=5 -> next cycle valid=1, wb_data=0x1234, wb_en=1, no req.
//  - SB addr=0x1003 data=0xAB, ack after 3 cycles -> be=1000, wdata=0xABABABAB,
//    dmem_addr=0x1000, stall_out=1 for 3 cycles, wb_en=0.
//  - LB addr=0x2001, rdata=0x0000_8000, immediate ack -> wb_data=0xFFFF_FF80;
//    LBU same -> 0x0000_0080.
//  - LW addr=0x2002: with MEM_MISALIGN_EXC_EN -> exc_valid=1 code 4, no req;
//    without -> dmem_addr=0x2000, be=1111.
//  - flush_in with LOAD at input in IDLE -> no dmem_req; flush_in during BUSY -> access completes.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: LOAD/STORE stage over a req/ack data memory; define MEM_MISALIGN_EXC_EN to trap misaligned H/W accesses.
// Latency 1 cycle for pass-through, >=2 for memory; stall_out holds execute for the whole outstanding access.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int EX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipeline_in_valid,
    input  logic [4:0]        opcode_in,
    input  logic [2:0]        funct_in,
    input  logic              nop_instr_in,
    input  logic [EX_W-1:0]   exception_in,
    input  logic              exception_in_valid,
    input  logic [DATA_W-1:0] result,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [4:0]        rd_addr_in,
    input  logic              flush_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              pipeline_out_valid,
    output logic [4:0]        rd_addr_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    output logic [EX_W-1:0]   exception_out,
    output logic              exception_out_valid
);

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

`ifdef MEM_MISALIGN_EXC_EN
    localparam bit MISALIGN_EXC = 1'b1;
`else
    localparam bit MISALIGN_EXC = 1'b0;
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic              stall_q, stall_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        funct_q, funct_d;
    logic [1:0]        lane_q, lane_d;
    logic              ld_en_q, ld_en_d;
    logic              out_vld_q, out_vld_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_en_q, wb_en_d;
    logic [EX_W-1:0]   exc_q, exc_d;
    logic              exc_vld_q, exc_vld_d;

    logic              capture, is_load, is_store, is_mem, misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        req_be;
    logic [DATA_W-1:0] req_wdata, ld_val;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign capture  = pipeline_in_valid && !flush_in && (state_q == IDLE);
    assign is_load  = (opcode_in == OP_LOAD);
    assign is_store = (opcode_in == OP_STORE);
    assign is_mem   = (is_load || is_store) && !nop_instr_in && !exception_in_valid;
    assign mem_addr = is_store ? store_addr : result[ADDR_W-1:0];

    // funct[1:0] encodes access size for both loads and stores; funct[2] is the unsigned flag
    always_comb begin
        req_be     = 4'b1111;
        req_wdata  = result;
        misaligned = 1'b0;
        case (funct_in[1:0])
            2'b00: begin
                req_be    = 4'b0001 << mem_addr[1:0];
                req_wdata = {(DATA_W/8){result[7:0]}};
            end
            2'b01: begin
                req_be     = mem_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata  = {(DATA_W/16){result[15:0]}};
                misaligned = mem_addr[0];
            end
            default: misaligned = |mem_addr[1:0];
        endcase
    end

    assign ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
    assign ld_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_val = dmem_rdata;
        case (funct_q[1:0])
            2'b00:   ld_val = funct_q[2] ? {{(DATA_W-8){1'b0}}, ld_byte}
                                         : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = funct_q[2] ? {{(DATA_W-16){1'b0}}, ld_half}
                                         : {{(DATA_W-16){ld_half[15]}}, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        stall_d   = stall_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        funct_d   = funct_q;
        lane_d    = lane_q;
        ld_en_d   = ld_en_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        exc_d     = exc_q;
        out_vld_d = 1'b0;
        wb_en_d   = 1'b0;
        exc_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    rd_d = rd_addr_in;
                    if (is_mem && !(MISALIGN_EXC && misaligned)) begin
                        state_d = BUSY;
                        stall_d = 1'b1;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                        be_d    = req_be;
                        wdata_d = is_store ? req_wdata : '0;
                        funct_d = funct_in;
                        lane_d  = mem_addr[1:0];
                        ld_en_d = is_load && (rd_addr_in != 5'd0);
                    end else begin
                        out_vld_d = 1'b1;
                        wb_data_d = result;
                        exc_d     = exception_in;
                        exc_vld_d = exception_in_valid;
                        wb_en_d   = !nop_instr_in && !exception_in_valid && !is_store
                                    && (rd_addr_in != 5'd0);
                        // only reachable for memory ops when misaligned accesses trap
                        if (is_mem) begin
                            exc_vld_d = 1'b1;
                            exc_d     = is_load ? EX_W'(4) : EX_W'(6);
                            wb_en_d   = 1'b0;
                        end
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d   = IDLE;
                    stall_d   = 1'b0;
                    req_d     = 1'b0;
                    out_vld_d = 1'b1;
                    wb_en_d   = ld_en_q;
                    wb_data_d = we_q ? '0 : ld_val;
                    exc_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            stall_q   <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            funct_q   <= '0;
            lane_q    <= '0;
            ld_en_q   <= 1'b0;
            out_vld_q <= 1'b0;
            rd_q      <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            exc_q     <= '0;
            exc_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            funct_q   <= funct_d;
            lane_q    <= lane_d;
            ld_en_q   <= ld_en_d;
            out_vld_q <= out_vld_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
            exc_q     <= exc_d;
            exc_vld_q <= exc_vld_d;
        end
    end

    assign stall_out           = stall_q;
    assign dmem_req            = req_q;
    assign dmem_we             = we_q;
    assign dmem_addr           = addr_q;
    assign dmem_wdata          = wdata_q;
    assign dmem_be             = be_q;
    assign pipeline_out_valid  = out_vld_q;
    assign rd_addr_out         = rd_q;
    assign wb_data             = wb_data_q;
    assign wb_en               = wb_en_q;
    assign exception_out       = exc_q;
    assign exception_out_valid = exc_vld_q;

endmodule
